// File: rtl/cmac_tx_buf_pkg.sv
// Shared types and constants for the CMAC TX store-and-forward packet buffer.
package cmac_tx_buf_pkg;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wr_state_e;

    // One buffer entry holds {tuser, tlast, tkeep, tdata}.
    function automatic int entry_width(input int data_w, input int keep_w);
        return data_w + keep_w + 2;
    endfunction

endpackage

// File: rtl/cmac_tx_buf_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with 1-cycle latency.
module cmac_tx_buf_ram #(
    parameter int WIDTH      = 578,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: only the read register is reset; clearing the array would prevent block-RAM mapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cmac_tx_pkt_buffer.sv
// Store-and-forward packet FIFO from the ERNIC stream to the CMAC TX AXIS port.
// Optional statistics outputs are enabled with the CMAC_TX_BUF_STATS_EN macro.
module cmac_tx_pkt_buffer #(
    parameter int DATA_W     = cmac_tx_buf_pkg::DATA_W,
    parameter int KEEP_W     = cmac_tx_buf_pkg::KEEP_W,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [KEEP_W-1:0]     s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [KEEP_W-1:0]     m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic [15:0]           pkt_drop_cnt,
    output logic [DEPTH_LOG2:0]   buf_pkts
`ifdef CMAC_TX_BUF_STATS_EN
    ,
    output logic [31:0]           tx_pkt_cnt,
    output logic [47:0]           tx_byte_cnt,
    output logic [DEPTH_LOG2:0]   max_fill
`endif
);

    import cmac_tx_buf_pkg::*;

    localparam int                PTR_W    = DEPTH_LOG2 + 1;
    localparam int                ENTRY_W  = entry_width(DATA_W, KEEP_W);
    localparam logic [PTR_W-1:0]  CAPACITY = PTR_W'(2**DEPTH_LOG2);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    wr_state_e          state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]   wr_commit, wr_commit_nxt;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_addr;
    logic [PTR_W-1:0]   occupancy;
    logic [PTR_W-1:0]   free_slots;
    logic               buf_full;
    logic               ready_q;
    logic               in_fire;
    logic               wr_en;
    logic               commit;
    logic               drop;
    logic               rd_en;
    logic               out_valid;
    logic               out_fire;
    logic               pkt_pop;
    logic               q_last;
    logic               q_user;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_q;

    // rd_ptr releases a slot only once its beat leaves the output stage, so the
    // beat held there still counts as occupied.
    assign occupancy  = wr_ptr - rd_ptr;
    assign free_slots = CAPACITY - occupancy;
    assign buf_full   = (free_slots == '0);

    assign s_axis_tready = ready_q;
    assign in_fire       = s_axis_tvalid && ready_q;
    assign wr_entry      = {s_axis_tuser & s_axis_tlast, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        wr_en         = 1'b0;
        commit        = 1'b0;
        drop          = 1'b0;
        if (in_fire) begin
            case (state)
                IDLE, FILL: begin
                    if (buf_full) begin
                        // Overflow: roll back to the last committed packet boundary.
                        wr_ptr_nxt = wr_commit;
                        if (s_axis_tlast) begin
                            drop      = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DROP;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                        if (s_axis_tlast) begin
                            wr_commit_nxt = wr_ptr + PTR_ONE;
                            commit        = 1'b1;
                            state_nxt     = IDLE;
                        end else begin
                            state_nxt = FILL;
                        end
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Only committed beats are read, so a started packet always streams without gaps.
    assign rd_en    = (rd_addr != wr_commit) && (!out_valid || m_axis_tready);
    assign out_fire = out_valid && m_axis_tready;
    assign pkt_pop  = out_fire && q_last;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            wr_commit    <= '0;
            rd_ptr       <= '0;
            rd_addr      <= '0;
            out_valid    <= 1'b0;
            ready_q      <= 1'b0;
            buf_pkts     <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
            ready_q   <= 1'b1;

            if (rd_en) begin
                rd_addr   <= rd_addr + PTR_ONE;
                out_valid <= 1'b1;
            end else if (m_axis_tready) begin
                out_valid <= 1'b0;
            end

            if (out_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (commit && !pkt_pop) begin
                buf_pkts <= buf_pkts + PTR_ONE;
            end else if (pkt_pop && !commit) begin
                buf_pkts <= buf_pkts - PTR_ONE;
            end

            if (drop && (pkt_drop_cnt != 16'hFFFF)) begin
                pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
            end
        end
    end

    cmac_tx_buf_ram #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_addr (rd_addr[DEPTH_LOG2-1:0]),
        .rd_data (rd_q)
    );

    assign q_last        = rd_q[DATA_W+KEEP_W];
    assign q_user        = rd_q[DATA_W+KEEP_W+1];
    assign m_axis_tdata  = rd_q[DATA_W-1:0];
    assign m_axis_tkeep  = rd_q[DATA_W +: KEEP_W];
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_valid & q_last;
    assign m_axis_tuser  = out_valid & q_last & q_user;

`ifdef CMAC_TX_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_pkt_cnt  <= '0;
            tx_byte_cnt <= '0;
            max_fill    <= '0;
        end else begin
            if (pkt_pop) begin
                tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
            end
            if (out_fire) begin
                tx_byte_cnt <= tx_byte_cnt + 48'($countones(m_axis_tkeep));
            end
            if (occupancy > max_fill) begin
                max_fill <= occupancy;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmac_tx_pkt_buffer.sv
// Scoreboard bench for cmac_tx_pkt_buffer: stimulus pushes expected beats, a monitor pops and compares.
`timescale 1ns/1ps
module tb_cmac_tx_pkt_buffer;

    localparam int DATA_W     = 512;
    localparam int KEEP_W     = 64;
    localparam int DEPTH_LOG2 = 6;

    typedef struct packed {
        logic              user;
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [DATA_W-1:0]     s_axis_tdata = '0;
    logic [KEEP_W-1:0]     s_axis_tkeep = '0;
    logic                  s_axis_tvalid = 1'b0;
    logic                  s_axis_tlast = 1'b0;
    logic                  s_axis_tuser = 1'b0;
    logic                  s_axis_tready;
    logic [DATA_W-1:0]     m_axis_tdata;
    logic [KEEP_W-1:0]     m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;
    logic                  m_axis_tready = 1'b0;
    logic [15:0]           pkt_drop_cnt;
    logic [DEPTH_LOG2:0]   buf_pkts;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    tlast_cyc = 0;
    int    pop_count = 0;
    int    first_pop_cyc = 0;
    int    last_pop_cyc = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: toggle, 2: held low

    cmac_tx_pkt_buffer #(
        .DATA_W     (DATA_W),
        .KEEP_W     (KEEP_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .pkt_drop_cnt  (pkt_drop_cnt),
        .buf_pkts      (buf_pkts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented beat with the scoreboard head; pops on acceptance.
    always @(negedge clk) begin
        beat_t got;
        if (!reset && m_axis_tvalid) begin
            got = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (sb.size() == 0) begin
                check("unexpected_beat_sb_level", sb.size(), 1);
            end else begin
                check(m_axis_tready ? "beat" : "stall_hold", got, sb[0]);
                if (m_axis_tready) begin
                    void'(sb.pop_front());
                    if (pop_count == 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    pop_count++;
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] beat_data(input int pid, input int b);
        logic [31:0] w;
        w = 32'(pid * 65536 + b) ^ 32'hA500_0000;
        return {16{w}};
    endfunction

    task automatic drive_beat(input int pid, input int b, input int nbeats,
                              input logic [KEEP_W-1:0] last_keep, input logic user,
                              input bit expect_out);
        beat_t bt;
        bt.data = beat_data(pid, b);
        bt.last = (b == nbeats - 1);
        bt.keep = bt.last ? last_keep : '1;
        bt.user = bt.last & user;
        s_axis_tdata  = bt.data;
        s_axis_tkeep  = bt.keep;
        s_axis_tlast  = bt.last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        if (bt.last) tlast_cyc = cyc;
        if (expect_out) sb.push_back(bt);
    endtask

    task automatic idle_inputs();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic send_pkt(input int pid, input int nbeats, input logic [KEEP_W-1:0] last_keep,
                            input logic user, input bit expect_out);
        for (int b = 0; b < nbeats; b++) begin
            drive_beat(pid, b, nbeats, last_keep, user, expect_out);
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_drain_left"}, sb.size(), 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_buf_pkts", buf_pkts, 0);
        check("rst_drop_cnt", pkt_drop_cnt, 0);
        check("rst_s_tready", s_axis_tready, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("s_tready_after_rst", s_axis_tready, 1);

        // 1: 9-beat 522-byte packet, latency and contiguity
        pop_count = 0;
        send_pkt(1, 9, 64'h3FF, 1'b0, 1'b1);
        wait_drain("t1");
        check("t1_latency", first_pop_cyc - tlast_cyc, 2);
        check("t1_contiguous", last_pop_cyc - first_pop_cyc, 8);
        check("t1_pop_count", pop_count, 9);
        check("t1_drop_cnt", pkt_drop_cnt, 0);

        // 2: three 2-beat packets with toggling tready
        rdy_mode = 1;
        pop_count = 0;
        send_pkt(2, 2, 64'hFFFF, 1'b0, 1'b1);
        send_pkt(3, 2, 64'h00FF, 1'b0, 1'b1);
        send_pkt(4, 2, 64'h0F0F, 1'b0, 1'b1);
        wait_drain("t2");
        rdy_mode = 0;
        check("t2_pop_count", pop_count, 6);
        check("t2_buf_pkts", buf_pkts, 0);

        // 3: 65-beat packet dropped, following 4-beat packet intact
        send_pkt(10, 65, '1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t3_drop_cnt", pkt_drop_cnt, 1);
        check("t3_wr_commit_kept", dut.wr_commit, 15);
        check("t3_buf_pkts_after_drop", buf_pkts, 0);
        send_pkt(11, 4, 64'h0000_0000_0000_000F, 1'b0, 1'b1);
        wait_drain("t3");
        check("t3_wr_commit_next", dut.wr_commit, 19);
        check("t3_buf_pkts", buf_pkts, 0);

        // 4: fill 63 beats with tready low, then an overflowing 2-beat packet
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rdy_mode = 2;
        @(posedge clk); #1;
        check("t4_drop_cnt_cleared", pkt_drop_cnt, 0);
        for (int p = 0; p < 7; p++) begin
            send_pkt(20 + p, 9, '1, 1'b0, 1'b1);
        end
        send_pkt(30, 2, '1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t4_drop_cnt", pkt_drop_cnt, 1);
        check("t4_buf_pkts_full", buf_pkts, 7);
        check("t4_tvalid_stalled", m_axis_tvalid, 1);
        pop_count = 0;
        rdy_mode = 0;
        wait_drain("t4");
        check("t4_pop_count", pop_count, 63);
        check("t4_buf_pkts", buf_pkts, 0);

        // 5: tuser only on the output tlast beat
        send_pkt(40, 3, 64'h0000_0000_0000_00FF, 1'b1, 1'b1);
        wait_drain("t5");
        check("t5_drop_cnt", pkt_drop_cnt, 1);

        // 6: reset during beat 3 of a 9-beat transfer
        for (int b = 0; b < 2; b++) begin
            drive_beat(50, b, 9, '1, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        drive_beat(50, 2, 9, '1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        check("t6_tvalid", m_axis_tvalid, 0);
        check("t6_buf_pkts", buf_pkts, 0);
        check("t6_drop_cnt", pkt_drop_cnt, 0);
        check("t6_s_tready_in_rst", s_axis_tready, 0);
        @(posedge clk); #1;
        check("t6_s_tready_after", s_axis_tready, 1);
        pop_count = 0;
        send_pkt(51, 5, 64'h0000_0000_0000_FFFF, 1'b0, 1'b1);
        wait_drain("t6");
        check("t6_pop_count", pop_count, 5);
        check("t6_buf_pkts_end", buf_pkts, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmac_tx_pkt_buffer.md
Name: cmac_tx_pkt_buffer

Overview:
Store-and-forward packet FIFO between the ERNIC stream output (cmac_m_axis_*) and the CMAC TX AXIS port (tx_axis_*), both in the txusrclk2 domain.
- Forwards a packet to CMAC only after its last beat is stored, so tx_axis_tvalid never deasserts mid-packet and tx_unfout cannot fire.
- Drops a packet that overflows the buffer as a whole, rolling back the write pointer; never truncates.

Parameters:
DATA_W, 512, AXIS data width in bits
KEEP_W, 64, tkeep width (DATA_W/8)
DEPTH_LOG2, 6, log2 of buffer depth in beats (64 beats = 4 KB)

Ports:
clk  in  1  txusrclk2; all logic on rising edge
reset  in  1  usr_tx_reset; synchronous, active-high
s_axis_tdata  in  DATA_W  packet data from ERNIC
s_axis_tkeep  in  KEEP_W  byte enables
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  last beat of packet
s_axis_tuser  in  1  packet error flag, sampled on the tlast beat
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_W  to CMAC tx_axis_tdata
m_axis_tkeep  out  KEEP_W  to CMAC tx_axis_tkeep
m_axis_tvalid  out  1  to CMAC tx_axis_tvalid
m_axis_tlast  out  1  to CMAC tx_axis_tlast
m_axis_tuser  out  1  to CMAC tx_axis_tuser; driven 0 except on the tlast beat
m_axis_tready  in  1  from CMAC tx_axis_tready
pkt_drop_cnt  out  16  packets dropped since reset; saturates at 0xFFFF
buf_pkts  out  DEPTH_LOG2+1  complete packets currently stored

Behaviour:
- Reset state: all outputs 0, except s_axis_tready = 1 one cycle after reset deasserts. Pointers, counters and state are cleared.
- Reset mid-operation: the partial packet and all stored packets are discarded.
- Storage entry: {tuser, tlast, tkeep, tdata}.
- Pointers: wr_ptr, wr_commit, rd_ptr, each DEPTH_LOG2+1 bits with a wrap bit.
  - free = 2^DEPTH_LOG2 − (wr_ptr − rd_ptr), modulo arithmetic.
- Write FSM states are IDLE, FILL and DROP.
  - IDLE: on a valid beat, go to FILL and write the beat. A single-beat packet (tlast set) commits and stays in IDLE.
  - FILL: write each valid beat.
    - If a valid beat arrives while free == 0: set wr_ptr = wr_commit and go to DROP. If that beat has tlast, increment the drop count and go to IDLE instead.
    - On a tlast beat that is written: set wr_commit = wr_ptr+1 and increment buf_pkts.
  - DROP: discard beats until tlast, then increment pkt_drop_cnt and go to IDLE.
- s_axis_tready stays 1 outside reset; input is never back-pressured.
- Read side: one-beat prefetch register after the synchronous-read RAM.
  - m_axis_tvalid asserts only when buf_pkts > 0 or a packet is in flight, and stays high until its tlast beat is accepted.
  - Output is held stable while tvalid && !tready.
  - On acceptance of a tlast beat, buf_pkts is decremented.
- Latency, with the buffer empty and m_axis_tready = 1: input tlast beat accepted in cycle N → first beat on m_axis in cycle N+2. Streaming after that is one beat per cycle.
- Same-cycle commit and pop: buf_pkts is unchanged. Same-cycle write and read of the last free slot is legal; free is computed from registered pointers.
- A packet longer than 2^DEPTH_LOG2 beats is always dropped.
- Width rule: buf_pkts cannot exceed 2^DEPTH_LOG2, because the minimum packet is one beat.

Optional Feature:
CMAC_TX_BUF_STATS_EN
- Defined: adds outputs tx_pkt_cnt[31:0] (packets forwarded), tx_byte_cnt[47:0] (sum of popcount(tkeep) over forwarded beats) and max_fill[DEPTH_LOG2:0] (high-water mark of occupied beats). All wrap modulo width and reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cmac_tx_buf_pkg:
  - write FSM enum {IDLE, FILL, DROP}
  - constants DATA_W = 512, KEEP_W = 64
  - a function computing the entry width
- Sub-module cmac_tx_buf_ram: simple dual-port RAM with synchronous read, 1-cycle latency, parameterised width and depth.
- Pointer, FSM and prefetch logic stay in the top.

Test Plan:
1. One 522-byte packet (9 beats, last tkeep = 64'h3FF), m_axis_tready = 1 → 9 contiguous output beats starting 2 cycles after input tlast; data and tkeep identical to input; pkt_drop_cnt = 0.
2. Three 2-beat packets back-to-back with m_axis_tready toggling 1/0 each cycle → all 6 beats delivered in order; output held stable while stalled; buf_pkts returns to 0.
3. DEPTH_LOG2 = 6, 65-beat packet, then a 4-beat packet → first packet absent from output; pkt_drop_cnt = 1; second packet output intact; wr_commit unaffected by the drop.
4. m_axis_tready = 0; fill with 63 beats in complete packets; then a 2-beat packet → second beat overflows, that packet is dropped, pkt_drop_cnt = 1; after releasing tready all earlier packets drain correctly.
5. Input tlast beat with tuser = 1 → m_axis_tuser = 1 only on the output tlast beat.
6. Assert reset for 1 cycle during beat 3 of a 9-beat transfer → m_axis_tvalid = 0 next cycle; buf_pkts = 0; pkt_drop_cnt = 0; the next packet after reset is forwarded intact.
